// File: rtl/i2c_gain_master.sv
// rtl/i2c_gain_master.sv - I2C master that writes/reads 6-bit PID gain registers on one target.
// Optional target clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_gain_master #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         CLK_DIV  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_reg_addr,
    input  logic [5:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [5:0] rsp_rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [3:0] {
        IDLE, START, SEND, RACK, RSTART, RECV, MNACK, STOP, DONE
    } state_t;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state, state_next;
    logic [7:0] qcnt;
    logic [1:0] quarter;
    logic [3:0] bit_cnt;
    logic [1:0] phase;
    logic [7:0] tx_shift;
    logic [5:0] rx_shift;
    logic       lat_rw;
    logic [7:0] lat_reg;
    logic [5:0] lat_wdata;
    logic       scl_pull, sda_pull, bit_state;
    logic       stall, qend, bit_end, sample;

`ifdef I2C_CLOCK_STRETCH_EN
    // SCL released by us but still low means the target is stretching.
    assign stall = !scl_pull && !scl_i && (state != IDLE) && (state != DONE);
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stall = 1'b0;
`endif

    assign qend    = (qcnt == QMAX) && !stall;
    assign bit_end = qend && (quarter == 2'd3);
    assign sample  = qend && (quarter == 2'd2);

    assign bit_state = (state == SEND) || (state == RACK) || (state == RSTART) ||
                       (state == RECV) || (state == MNACK) || (state == STOP);

    always_comb begin
        scl_pull = bit_state && !quarter[1];
        sda_pull = 1'b0;
        case (state)
            START:   sda_pull = 1'b1;
            SEND:    sda_pull = !tx_shift[7];
            RSTART:  sda_pull = (quarter == 2'd3);
            STOP:    sda_pull = (quarter != 2'd3);
            default: sda_pull = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = START;
            START:   if (qend) state_next = SEND;
            SEND:    if (bit_end && bit_cnt == 4'd7) state_next = RACK;
            RACK: begin
                if (bit_end) begin
                    if (rsp_nack)
                        state_next = STOP;
                    else if (phase == 2'd0)
                        state_next = SEND;
                    else if (phase == 2'd1)
                        state_next = lat_rw ? RSTART : SEND;
                    else
                        state_next = lat_rw ? RECV : STOP;
                end
            end
            RSTART:  if (bit_end) state_next = SEND;
            RECV:    if (bit_end && bit_cnt == 4'd7) state_next = MNACK;
            MNACK:   if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qcnt      <= 8'd0;
            quarter   <= 2'd0;
            bit_cnt   <= 4'd0;
            phase     <= 2'd0;
            tx_shift  <= 8'd0;
            rx_shift  <= 6'd0;
            lat_rw    <= 1'b0;
            lat_reg   <= 8'd0;
            lat_wdata <= 6'd0;
            rsp_nack  <= 1'b0;
            rsp_rdata <= 6'd0;
        end else begin
            state <= state_next;

            if (state == IDLE || state == DONE) begin
                qcnt    <= 8'd0;
                quarter <= 2'd0;
            end else if (!stall) begin
                if (qcnt == QMAX) begin
                    qcnt    <= 8'd0;
                    // START is a single quarter, so the first data bit starts at quarter 0.
                    quarter <= (state == START) ? 2'd0 : quarter + 2'd1;
                end else begin
                    qcnt <= qcnt + 8'd1;
                end
            end

            if (state == IDLE && cmd_valid) begin
                lat_rw    <= cmd_rw;
                lat_reg   <= cmd_reg_addr;
                lat_wdata <= cmd_wdata;
                tx_shift  <= {DEV_ADDR, 1'b0};
                phase     <= 2'd0;
                bit_cnt   <= 4'd0;
                rsp_nack  <= 1'b0;
            end

            if (sample) begin
                if (state == RACK) rsp_nack <= sda_i;
                if (state == RECV) rx_shift <= {rx_shift[4:0], sda_i};
            end

            if (bit_end) begin
                case (state)
                    SEND: begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    RECV: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) rsp_rdata <= rx_shift;
                    end
                    RACK: begin
                        bit_cnt <= 4'd0;
                        phase   <= phase + 2'd1;
                        if (phase == 2'd0)
                            tx_shift <= lat_reg;
                        else if (phase == 2'd1)
                            tx_shift <= lat_rw ? {DEV_ADDR, 1'b1} : {2'b00, lat_wdata};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset releases the bus in the same cycle it is asserted.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);
    assign scl_oe    = scl_pull && !rst;
    assign sda_oe    = sda_pull && !rst;

endmodule

// File: doc/i2c_gain_master.md
I2C_GAIN_MASTER -- requirements
Module: i2c_gain_master

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h42, meaning the 7-bit I2C target address of the gain register file.
REQ-002 The module SHALL have parameter CLK_DIV, default 16, meaning clk cycles per SCL quarter-period; legal range 2..255.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single system clock.
REQ-004 The module SHALL have port rst, input, 1 bit, meaning reset; one clock, reset synchronous and active-high.
REQ-005 The module SHALL have port cmd_valid, input, 1 bit, meaning a command is offered.
REQ-006 The module SHALL have port cmd_ready, output, 1 bit, meaning the command is accepted when it is high together with cmd_valid.
REQ-007 The module SHALL have port cmd_rw, input, 1 bit, meaning 0 for a register write and 1 for a register read.
REQ-008 The module SHALL have port cmd_reg_addr, input, 8 bits, meaning the target register address (0 = K_p, 1 = K_i, 2 = K_d).
REQ-009 The module SHALL have port cmd_wdata, input, 6 bits, meaning the gain value to write.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit, meaning a one-cycle pulse at transaction end.
REQ-011 The module SHALL have port rsp_nack, output, 1 bit, meaning the target NACKed; valid with rsp_valid.
REQ-012 The module SHALL have port rsp_rdata, output, 6 bits, meaning the read gain value; valid with rsp_valid when cmd_rw=1.
REQ-013 The module SHALL have ports scl_oe and sda_oe, outputs, 1 bit each, meaning 1 pulls the line low and 0 releases it; ports scl_i and sda_i, inputs, 1 bit each, meaning the sampled line levels.

Function
REQ-014 cmd_ready SHALL be high only in state IDLE; a handshake latches cmd_rw, cmd_reg_addr and cmd_wdata, and the START phase begins on the next cycle.
REQ-015 Each SCL bit SHALL be 4 quarter-periods of CLK_DIV cycles: SCL low, low, high, high. SDA SHALL change only at the start of the first quarter, and SDA SHALL be sampled at the end of the third quarter.
REQ-016 Write sequence: START, {DEV_ADDR,0}, ACK, cmd_reg_addr, ACK, {2'b00,cmd_wdata}, ACK, STOP.
REQ-017 Read sequence: START, {DEV_ADDR,0}, ACK, cmd_reg_addr, ACK, repeated START, {DEV_ADDR,1}, ACK, 8 data bits, master NACK, STOP.
REQ-018 Bytes SHALL be sent MSB first. rsp_rdata SHALL equal the low 6 bits of the received byte, and the upper 2 bits SHALL be ignored.
REQ-019 The FSM states SHALL be IDLE, START, SEND, RACK, RSTART, RECV, MNACK, STOP, DONE, with a 4-bit bit counter (0..8) and a byte-phase counter.
REQ-020 An ACK bit sampled as 1 SHALL abort the sequence: STOP is issued, then DONE with rsp_nack=1 and rsp_rdata unchanged.
REQ-021 START SHALL be SDA falling while SCL is high. STOP SHALL be SDA rising while SCL is high. Each condition SHALL be held for CLK_DIV cycles.
REQ-022 DONE SHALL last exactly one cycle, asserting rsp_valid, and then return to IDLE. cmd_ready SHALL rise on the following cycle.
REQ-023 cmd_valid SHALL be ignored outside IDLE, and latched command fields SHALL not change mid-transaction.
REQ-024 When idle, scl_oe and sda_oe SHALL be 0.

Reset
REQ-025 While rst=1, the state SHALL be IDLE, all counters 0, scl_oe=0, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_nack=0, rsp_rdata=0.
REQ-026 rst asserted mid-transaction SHALL abandon the transaction immediately by releasing both lines. No STOP SHALL be generated and no rsp_valid SHALL be issued.
REQ-027 cmd_ready SHALL go high the first cycle after rst deasserts.

Configuration
REQ-028 With macro I2C_CLOCK_STRETCH_EN defined, the quarter counter SHALL hold after SCL is released until scl_i=1, which supports target clock stretching.
REQ-029 With I2C_CLOCK_STRETCH_EN undefined, scl_i SHALL be ignored and timing SHALL be purely counter-based.

Verification
REQ-030 Write test: CLK_DIV=2, target model ACKs all bytes, write reg 1 = 6'h2A. The bus SHALL show 0x84, 0x01, 0x2A, each followed by an ACK, then STOP, then rsp_valid with rsp_nack=0.
REQ-031 Read test: read reg 2 with the model returning 0xD5. The bus SHALL show 0x84, 0x02, Sr, 0x85, then a master NACK. The response SHALL be rsp_rdata=6'h15 and rsp_nack=0.
REQ-032 NACK test: the model NACKs the address byte. A STOP SHALL follow the 9th SCL pulse, then rsp_valid=1, rsp_nack=1, and no further bytes.
REQ-033 Reset test: rst pulses during the register byte. scl_oe=0 and sda_oe=0 the next cycle, no rsp_valid, and cmd_ready=1 after release.
REQ-034 Stretch test: with I2C_CLOCK_STRETCH_EN, the model holds scl_i low for 50 cycles on bit 3. Transaction time SHALL extend by ≥50 cycles, and the data SHALL be unchanged.
REQ-035 Handshake test: cmd_valid held high across two back-to-back commands. Exactly one acceptance SHALL occur per transaction, and the second SHALL start only after rsp_valid.
